// File: rtl/multicycle_datapath.sv
// Multicycle datapath: register file, ALU and data memory sequenced by a READ/EXEC/MEM/WB FSM.
// One instruction is in flight at a time; a new start is accepted only in IDLE.
module multicycle_datapath #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int ADDR_W = 8,
   parameter int IMM_W  = 4
) (
   input  logic              reg_clc,
   input  logic              reg_reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [REG_AW-1:0] read_reg1,
   input  logic [REG_AW-1:0] read_reg2,
   input  logic [REG_AW-1:0] write_reg,
   input  logic [IMM_W-1:0]  imm_val,
   input  logic [ADDR_W-1:0] address,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] src1,
   output logic [DATA_W-1:0] src2,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] dm_out,
   output logic              zero,
   output logic              carry
);

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_ADDI  = 3'b100;
   localparam logic [2:0] OP_SHL   = 3'b101;
   localparam logic [2:0] OP_LOAD  = 3'b110;
   localparam logic [2:0] OP_STORE = 3'b111;
   localparam int         NREG     = 2**REG_AW;
   localparam int         DEPTH    = 2**ADDR_W;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_WB} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [2:0]          r_op;
   logic [REG_AW-1:0]   r_rs1, r_rs2, r_rd;
   logic [IMM_W-1:0]    r_imm;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_src1, r_src2, r_alu, r_dm;
   logic                r_zero, r_carry, r_done;
   logic [DATA_W-1:0]   r_rf  [NREG];
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W:0]     w_alu_full;
   logic [DATA_W:0]     w_imm_ext;
   logic                w_is_mem_op, w_commit, w_rf_we;
   logic [DATA_W-1:0]   w_wb_data;

   assign w_is_mem_op = (r_op == OP_LOAD) || (r_op == OP_STORE);
   assign w_commit    = (r_state == S_WB) || (r_state == S_MEM && r_op == OP_STORE);
   assign w_rf_we     = (r_state == S_WB);
   assign w_wb_data   = (r_op == OP_LOAD) ? r_dm : r_alu;
   assign w_imm_ext   = {{(DATA_W+1-IMM_W){1'b0}}, r_imm};

   always_ff @(posedge reg_clc) begin
      if (reg_reset) r_state <= S_IDLE;
      else           r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_READ;
         S_READ:  w_state_next = S_EXEC;
         S_EXEC:  w_state_next = w_is_mem_op ? S_MEM : S_WB;
         S_MEM:   w_state_next = (r_op == OP_LOAD) ? S_WB : S_IDLE;
         S_WB:    w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Bit DATA_W carries the carry-out for adds and the borrow for SUB.
   always_comb begin
      w_alu_full = '0;
      case (r_op)
         OP_ADD:  w_alu_full = {1'b0, r_src1} + {1'b0, r_src2};
         OP_SUB:  w_alu_full = {1'b0, r_src1} - {1'b0, r_src2};
         OP_AND:  w_alu_full = {1'b0, r_src1 & r_src2};
         OP_OR:   w_alu_full = {1'b0, r_src1 | r_src2};
         OP_ADDI: w_alu_full = {1'b0, r_src1} + w_imm_ext;
         OP_SHL:  w_alu_full = (32'(r_imm) >= DATA_W) ? '0 : {1'b0, r_src1 << r_imm};
         default: w_alu_full = '0;
      endcase
   end

   always_ff @(posedge reg_clc) begin
      if (reg_reset) begin
         r_op    <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
         r_imm   <= '0;
         r_addr  <= '0;
         r_src1  <= '0;
         r_src2  <= '0;
         r_alu   <= '0;
         r_dm    <= '0;
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_commit;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op   <= op;
                  r_rs1  <= read_reg1;
                  r_rs2  <= read_reg2;
                  r_rd   <= write_reg;
                  r_imm  <= imm_val;
                  r_addr <= address;
               end
            end
            S_READ: begin
               r_src1 <= r_rf[r_rs1];
               r_src2 <= r_rf[r_rs2];
            end
            S_EXEC: begin
               if (!w_is_mem_op) begin
                  r_alu   <= w_alu_full[DATA_W-1:0];
                  r_zero  <= (w_alu_full[DATA_W-1:0] == '0);
                  r_carry <= w_alu_full[DATA_W];
               end
            end
            S_MEM: begin
               if (r_op == OP_LOAD) r_dm <= r_mem[r_addr];
            end
            default: ;
         endcase
      end
   end

   // Data memory is never cleared; reset only suppresses an in-flight store.
   always_ff @(posedge reg_clc) begin
      if (!reg_reset && r_state == S_MEM && r_op == OP_STORE)
         r_mem[r_addr] <= r_src1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_rf
         always_ff @(posedge reg_clc) begin
            if (reg_reset)
               r_rf[gi] <= '0;
            else if (gi != 0 && w_rf_we && r_rd == REG_AW'(gi))
               r_rf[gi] <= w_wb_data;
         end
      end
   endgenerate

   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;
   assign src1    = r_src1;
   assign src2    = r_src2;
   assign alu_out = r_alu;
   assign dm_out  = r_dm;
   assign zero    = r_zero;
   assign carry   = r_carry;

endmodule
